// File: rtl/pe_packet_injector.sv
// PE-side packet injector: builds one routing flit per accepted request and
// offers it on the matching VC phase. Optional INJ_SEQ_EN adds a sequence number.
module pe_packet_injector #(
    parameter int SRC_X  = 0,
    parameter int SRC_Y  = 0,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        pe_req_valid,
    output logic        pe_req_ready,
    input  logic [3:0]  pe_dst_x,
    input  logic [3:0]  pe_dst_y,
    input  logic [31:0] pe_payload,
    input  logic        net_out_ready,
    output logic        net_out_valid,
    output logic [63:0] net_out_data,
    output logic        dst_err,
    output logic [15:0] pkt_count
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0] SX = 4'(SRC_X);
    localparam logic [3:0] SY = 4'(SRC_Y);
    localparam logic [4:0] MX = 5'(MESH_X);
    localparam logic [4:0] MY = 5'(MESH_Y);

    state_t     state;
    logic       vc_sel;
    logic       accept;
    logic       in_range;
    logic       dir_x;
    logic       dir_y;
    logic [3:0] hop_x;
    logic [3:0] hop_y;
    logic [7:0] seq_field;
    logic [63:0] flit;

    assign pe_req_ready = (state == IDLE) && !reset;
    assign accept       = pe_req_valid && pe_req_ready;
    assign in_range     = ({1'b0, pe_dst_x} < MX) && ({1'b0, pe_dst_y} < MY);

    always_comb begin
        dir_x = pe_dst_x < SX;
        dir_y = pe_dst_y < SY;
        hop_x = dir_x ? (SX - pe_dst_x) : (pe_dst_x - SX);
        hop_y = dir_y ? (SY - pe_dst_y) : (pe_dst_y - SY);
        flit  = {vc_sel, dir_x, dir_y, 5'd0, hop_x, hop_y,
                 SX, SY, seq_field, pe_payload};
    end

`ifdef INJ_SEQ_EN
    logic [7:0] seq;

    assign seq_field = seq;

    // Counts in-range accepts only; dropped requests consume no number.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= 8'd0;
        end else if (accept && in_range) begin
            seq <= seq + 8'd1;
        end
    end
`else
    assign seq_field = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            net_out_valid <= 1'b0;
            net_out_data  <= 64'd0;
            dst_err       <= 1'b0;
            pkt_count     <= 16'd0;
            vc_sel        <= 1'b0;
        end else begin
            dst_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            net_out_data  <= flit;
                            net_out_valid <= 1'b1;
                            state         <= SEND;
                        end else begin
                            dst_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // Router only takes the flit in the phase matching its VC.
                    if (net_out_ready && (polarity == vc_sel)) begin
                        net_out_valid <= 1'b0;
                        vc_sel        <= ~vc_sel;
                        pkt_count     <= pkt_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
